// File: rtl/mem_pkg.sv
// Shared types for the burst memory access controller: FSM states and
// the width of the burst-length field.
package mem_pkg;

  localparam int LEN_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WR,
    SETUP,
    STROBE,
    SAMPLE,
    RESP,
    RELEASE
  } state_t;

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address and beat counter: loads start address/length, steps once per
// completed beat, wraps the address at numWords-1 by explicit compare.
module burst_addr_gen
  import mem_pkg::*;
#(
  parameter int numWords = 64,
  parameter int AW       = $clog2(numWords)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [AW-1:0]    load_addr,
  input  logic [LEN_W-1:0] load_len,
  output logic [AW-1:0]    addr,
  output logic             last
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(numWords - 1);

  logic [AW-1:0]    addr_reg;
  logic [LEN_W-1:0] count_reg;

  // Compare rather than rely on natural overflow so non-power-of-2 depths wrap correctly.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg  <= '0;
      count_reg <= '0;
    end else if (load) begin
      addr_reg  <= load_addr;
      count_reg <= load_len;
    end else if (step) begin
      addr_reg  <= (addr_reg == LAST_ADDR) ? '0 : addr_reg + AW'(1);
      count_reg <= count_reg - LEN_W'(1);
    end
  end

  assign addr = addr_reg;
  assign last = (count_reg == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Burst read/write controller for an asynchronous-style SRAM: address and
// direction are set up a cycle before the strobe and held until it drops.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int  wordSize = 4,
  parameter int  numWords = 64,
  localparam int AW       = $clog2(numWords)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reqValid,
  output logic                reqReady,
  input  logic                reqWrite,
  input  logic [AW-1:0]       reqAddr,
  input  logic [LEN_W-1:0]    reqLen,
  input  logic                wrValid,
  output logic                wrReady,
  input  logic [wordSize-1:0] wrData,
  output logic                rdValid,
  input  logic                rdReady,
  output logic [wordSize-1:0] rdData,
  output logic                memEnable,
  output logic                memReadWrite,
  output logic [AW-1:0]       memAddress,
  output logic [wordSize-1:0] memDataIn,
  input  logic [wordSize-1:0] memDataOut,
  output logic                busy
);

  state_t              state_reg, state_next;
  logic                cmd_write_reg;
  logic [wordSize-1:0] wr_data_reg;
  logic [wordSize-1:0] rd_data_reg;
  logic                accept;
  logic                beat_done;
  logic                last_beat;

  assign accept    = reqReady && reqValid;
  assign beat_done = ((state_reg == RESP) && rdReady) || (state_reg == RELEASE);

  burst_addr_gen #(
    .numWords (numWords),
    .AW       (AW)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      (beat_done),
    .load_addr (reqAddr),
    .load_len  (reqLen),
    .addr      (memAddress),
    .last      (last_beat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cmd_write_reg <= 1'b0;
      wr_data_reg   <= '0;
      rd_data_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) cmd_write_reg <= reqWrite;
      if ((state_reg == WAIT_WR) && wrValid) wr_data_reg <= wrData;
      if (state_reg == SAMPLE) rd_data_reg <= memDataOut;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = reqWrite ? WAIT_WR : SETUP;
      WAIT_WR: if (wrValid) state_next = SETUP;
      SETUP:   state_next = STROBE;
      STROBE:  state_next = cmd_write_reg ? RELEASE : SAMPLE;
      SAMPLE:  state_next = RESP;
      RESP:    if (rdReady) state_next = last_beat ? IDLE : SETUP;
      RELEASE: state_next = last_beat ? IDLE : WAIT_WR;
      default: state_next = IDLE;
    endcase
  end

  // Strobe is masked by reset so an aborted write never commits at the reset edge.
  assign memEnable    = ((state_reg == STROBE) || (state_reg == SAMPLE)) && !reset;
  assign memReadWrite = ~cmd_write_reg;
  assign memDataIn    = wr_data_reg;
  assign rdData       = rd_data_reg;
  assign reqReady     = (state_reg == IDLE) && !reset;
  assign wrReady      = (state_reg == WAIT_WR);
  assign rdValid      = (state_reg == RESP);
  assign busy         = (state_reg != IDLE);

endmodule
